frame_weight_accum: RTL and testbench

Streaming stage that sits directly downstream of the 6-bit ones counter in the LLR initialisation path. It takes 6-bit words, computes each word's popcount internally (0..6), and accumulates the counts over a fixed-length frame. At frame end it presents the total Hamming weight, the frame parity and the peak per-word count through a valid/ready output register. The results feed frame-level weight/QBER bookkeeping ahead of LLR seeding.

---
 rtl/frame_weight_accum.sv | 109 ++++++++++
 tb/tb_frame_weight_accum.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_weight_accum.sv
// Frame-level Hamming weight accumulator: counts ones in 6-bit words over a fixed-length
// frame and hands the total weight, parity and peak per-word count out through a valid/ready register.
module frame_weight_accum #(
  parameter int WORDS_PER_FRAME = 64,
  parameter int CNT_W           = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_weight,
  output logic             out_parity,
  output logic [2:0]       out_maxw
);

  localparam int WC_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
  localparam logic [WC_W-1:0] LAST_IDX = WC_W'(WORDS_PER_FRAME - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           r_state;
  logic [WC_W-1:0]  r_word_cnt;
  logic [CNT_W-1:0] r_acc;
  logic [2:0]       r_maxw;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_out_weight;
  logic             r_out_parity;
  logic [2:0]       r_out_maxw;

  logic [2:0]       w_pc;
  logic             w_accept;
  logic             w_handoff;
  logic [CNT_W-1:0] w_acc_next;
  logic [2:0]       w_maxw_next;

  function automatic logic [2:0] popcount6(input logic [5:0] w);
    logic [2:0] s;
    s = '0;
    for (int k = 0; k < 6; k++) s = s + {2'b00, w[k]};
    return s;
  endfunction

  function automatic logic [2:0] max3(input logic [2:0] a, input logic [2:0] b);
    return (a > b) ? a : b;
  endfunction

  assign w_pc        = popcount6(in_data);
  assign w_accept    = in_valid && r_in_ready;
  assign w_handoff   = r_out_valid && out_ready;
  assign w_acc_next  = r_acc + CNT_W'(w_pc);
  assign w_maxw_next = max3(r_maxw, w_pc);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ACCUM;
      r_word_cnt   <= '0;
      r_acc        <= '0;
      r_maxw       <= '0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_weight <= '0;
      r_out_parity <= 1'b0;
      r_out_maxw   <= '0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            if (r_word_cnt == LAST_IDX) begin
              // Final word of the frame: publish totals including this word and restart counters.
              r_out_weight <= w_acc_next;
              r_out_parity <= w_acc_next[0];
              r_out_maxw   <= w_maxw_next;
              r_out_valid  <= 1'b1;
              r_in_ready   <= 1'b0;
              r_state      <= HOLD;
              r_word_cnt   <= '0;
              r_acc        <= '0;
              r_maxw       <= '0;
            end else begin
              r_word_cnt <= r_word_cnt + WC_W'(1);
              r_acc      <= w_acc_next;
              r_maxw     <= w_maxw_next;
            end
          end
        end
        HOLD: begin
          // Result registers are left untouched after handoff so the last frame stays visible.
          if (w_handoff) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ACCUM;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_weight = r_out_weight;
  assign out_parity = r_out_parity;
  assign out_maxw   = r_out_maxw;

endmodule

// File: tb/tb_frame_weight_accum.sv
// Bench for frame_weight_accum: three instances (4-word, 64-word and 1-word frames)
// checked against a frame-level model built from the stored words of each frame.
module tb_frame_weight_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] vin;
  logic [2:0] ordy;
  logic [5:0] din [3];
  wire  [2:0] ir, ov, op;
  wire  [2:0] omx [3];
  wire  [4:0] wa;
  wire  [8:0] wb;
  wire  [2:0] wc;

  int total = 0;
  int bad   = 0;

  // Reference model: words of the open frame, hold flag and last published result per instance.
  logic [5:0] mw [3][64];
  int         mn [3];
  bit         mh [3];
  logic [8:0] ew [3];
  bit         ep [3];
  logic [2:0] em [3];

  always #5 clk = ~clk;

  frame_weight_accum #(.WORDS_PER_FRAME(4), .CNT_W(5)) u_a (
    .clk(clk), .rst(rst), .in_valid(vin[0]), .in_ready(ir[0]), .in_data(din[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_weight(wa), .out_parity(op[0]), .out_maxw(omx[0]));

  frame_weight_accum #(.WORDS_PER_FRAME(64), .CNT_W(9)) u_b (
    .clk(clk), .rst(rst), .in_valid(vin[1]), .in_ready(ir[1]), .in_data(din[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_weight(wb), .out_parity(op[1]), .out_maxw(omx[1]));

  frame_weight_accum #(.WORDS_PER_FRAME(1), .CNT_W(3)) u_c (
    .clk(clk), .rst(rst), .in_valid(vin[2]), .in_ready(ir[2]), .in_data(din[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_weight(wc), .out_parity(op[2]), .out_maxw(omx[2]));

  function automatic int wpf(input int i);
    case (i)
      0:       return 4;
      1:       return 64;
      default: return 1;
    endcase
  endfunction

  function automatic logic [8:0] dut_w(input int i);
    case (i)
      0:       return {4'b0000, wa};
      1:       return wb;
      default: return {6'b000000, wc};
    endcase
  endfunction

  task automatic tick();
    bit acc [3];
    bit hs  [3];
    int s, m, c;
    for (int i = 0; i < 3; i++) begin
      acc[i] = vin[i] && !mh[i];
      hs[i]  = mh[i] && ordy[i];
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mn[i] = 0; mh[i] = 1'b0; ew[i] = '0; ep[i] = 1'b0; em[i] = '0;
      end else if (acc[i]) begin
        mw[i][mn[i]] = din[i];
        mn[i]++;
        if (mn[i] == wpf(i)) begin
          s = 0; m = 0;
          for (int k = 0; k < wpf(i); k++) begin
            c = $countones(mw[i][k]);
            s += c;
            if (c > m) m = c;
          end
          ew[i] = 9'(s); ep[i] = s[0]; em[i] = 3'(m);
          mh[i] = 1'b1; mn[i] = 0;
        end
      end else if (hs[i]) begin
        mh[i] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; vin = '0; ordy = '0;
    for (int i = 0; i < 3; i++) din[i] = '0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({ov[i], ir[i], op[i], omx[i], dut_w(i)} !== {1'b0, 1'b1, 1'b0, 3'd0, 9'd0}) begin
        bad++;
        $display("FAIL reset_state inst=%0d got v=%b r=%b p=%b m=%0d w=%0d want v=0 r=1 p=0 m=0 w=0",
                 i, ov[i], ir[i], op[i], omx[i], dut_w(i));
      end
    end
  endtask

  task automatic test_basic();
    logic [5:0] w [4];
    w[0] = 6'b000000; w[1] = 6'b111111; w[2] = 6'b101010; w[3] = 6'b000111;
    ordy[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vin[0] = 1'b1; din[0] = w[k];
      tick();
      if (k < 3) begin
        total++;
        if (ov[0] !== 1'b0) begin bad++; $display("FAIL basic_early_valid k=%0d got=%b want=0", k, ov[0]); end
      end
    end
    vin[0] = 1'b0;
    total++;
    if ({ov[0], ir[0], wa, op[0], omx[0]} !== {1'b1, 1'b0, 5'd12, 1'b0, 3'd6}) begin
      bad++;
      $display("FAIL basic_result got v=%b r=%b w=%0d p=%b m=%0d want v=1 r=0 w=12 p=0 m=6", ov[0], ir[0], wa, op[0], omx[0]);
    end
    tick();
    total++;
    if ({ov[0], ir[0], wa, omx[0]} !== {1'b0, 1'b1, 5'd12, 3'd6}) begin
      bad++;
      $display("FAIL basic_after_handoff got v=%b r=%b w=%0d m=%0d want v=0 r=1 w=12 m=6", ov[0], ir[0], wa, omx[0]);
    end
  endtask

  task automatic test_backpressure();
    ordy[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vin[0] = 1'b1; din[0] = 6'($urandom);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      vin[0] = 1'b1; din[0] = 6'b111111;
      tick();
      total++;
      if ({ov[0], ir[0], wa, op[0], omx[0]} !== {1'b1, 1'b0, ew[0][4:0], ep[0], em[0]}) begin
        bad++;
        $display("FAIL hold_stable k=%0d got v=%b r=%b w=%0d p=%b m=%0d want v=1 r=0 w=%0d p=%b m=%0d",
                 k, ov[0], ir[0], wa, op[0], omx[0], ew[0], ep[0], em[0]);
      end
    end
    vin[0] = 1'b0; ordy[0] = 1'b1;
    tick();
    total++;
    if ({ov[0], ir[0]} !== 2'b01) begin
      bad++; $display("FAIL hold_release got v=%b r=%b want v=0 r=1", ov[0], ir[0]);
    end
    for (int k = 0; k < 4; k++) begin
      vin[0] = 1'b1; din[0] = 6'b000001;
      tick();
    end
    vin[0] = 1'b0;
    total++;
    if ({ov[0], wa, op[0], omx[0]} !== {1'b1, 5'd4, 1'b0, 3'd1}) begin
      bad++;
      $display("FAIL hold_no_consume got v=%b w=%0d p=%b m=%0d want v=1 w=4 p=0 m=1", ov[0], wa, op[0], omx[0]);
    end
    tick();
  endtask

  task automatic test_gaps();
    logic [5:0] w [4];
    w[0] = 6'b000011; w[1] = 6'b000001; w[2] = 6'b000001; w[3] = 6'b000000;
    ordy[0] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      vin[0] = (k % 2 == 0); din[0] = w[k / 2];
      tick();
      total++;
      if (k < 6) begin
        if (ov[0] !== 1'b0) begin bad++; $display("FAIL gaps_early k=%0d got v=%b want v=0", k, ov[0]); end
      end else if ({ov[0], wa, op[0], omx[0]} !== {1'b1, 5'd4, 1'b0, 3'd2}) begin
        bad++;
        $display("FAIL gaps_result got v=%b w=%0d p=%b m=%0d want v=1 w=4 p=0 m=2", ov[0], wa, op[0], omx[0]);
      end
    end
    vin[0] = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    ordy[0] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      vin[0] = 1'b1; din[0] = 6'b111111;
      tick();
    end
    vin[0] = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (ov[0] !== 1'b0) begin bad++; $display("FAIL abort_no_result k=%0d got v=%b want v=0", k, ov[0]); end
      vin[0] = 1'b1; din[0] = 6'b000001;
      tick();
    end
    vin[0] = 1'b0;
    total++;
    if ({ov[0], wa, op[0], omx[0]} !== {1'b1, 5'd4, 1'b0, 3'd1}) begin
      bad++;
      $display("FAIL abort_next_frame got v=%b w=%0d p=%b m=%0d want v=1 w=4 p=0 m=1", ov[0], wa, op[0], omx[0]);
    end
    tick();
  endtask

  task automatic test_reset_hold();
    ordy[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vin[0] = 1'b1; din[0] = 6'b110110;
      tick();
    end
    vin[0] = 1'b0;
    total++;
    if ({ov[0], wa} !== {1'b1, 5'd16}) begin
      bad++; $display("FAIL hold_rst_pre got v=%b w=%0d want v=1 w=16", ov[0], wa);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({ov[0], ir[0], wa, op[0], omx[0]} !== {1'b0, 1'b1, 5'd0, 1'b0, 3'd0}) begin
      bad++;
      $display("FAIL hold_rst_drop got v=%b r=%b w=%0d p=%b m=%0d want v=0 r=1 w=0 p=0 m=0", ov[0], ir[0], wa, op[0], omx[0]);
    end
    ordy[0] = 1'b1;
  endtask

  task automatic test_default_frame();
    ordy[1] = 1'b1;
    for (int k = 0; k < 64; k++) begin
      vin[1] = 1'b1; din[1] = 6'b111111;
      tick();
      if (k == 62) begin
        total++;
        if (ov[1] !== 1'b0) begin bad++; $display("FAIL full_early got v=%b want v=0", ov[1]); end
      end
    end
    vin[1] = 1'b0;
    total++;
    if ({ov[1], wb, op[1], omx[1]} !== {1'b1, 9'd384, 1'b0, 3'd6}) begin
      bad++;
      $display("FAIL full_ones got v=%b w=%0d p=%b m=%0d want v=1 w=384 p=0 m=6", ov[1], wb, op[1], omx[1]);
    end
    tick();
    for (int k = 0; k < 64; k++) begin
      vin[1] = 1'b1; din[1] = 6'b000001;
      tick();
    end
    vin[1] = 1'b0;
    total++;
    if ({ov[1], wb, op[1], omx[1]} !== {1'b1, 9'd64, 1'b0, 3'd1}) begin
      bad++;
      $display("FAIL full_lsb got v=%b w=%0d p=%b m=%0d want v=1 w=64 p=0 m=1", ov[1], wb, op[1], omx[1]);
    end
    tick();
  endtask

  task automatic test_single_word();
    logic [5:0] w [3];
    logic [6:0] e [3];
    w[0] = 6'b110000; w[1] = 6'b111000; w[2] = 6'b000000;
    e[0] = {3'd2, 1'b0, 3'd2}; e[1] = {3'd3, 1'b1, 3'd3}; e[2] = {3'd0, 1'b0, 3'd0};
    ordy[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vin[2] = 1'b1; din[2] = w[k];
      tick();
      total++;
      if ({ov[2], wc, op[2], omx[2]} !== {1'b1, e[k]}) begin
        bad++;
        $display("FAIL single_word k=%0d got v=%b w=%0d p=%b m=%0d want v=1 w=%0d p=%b m=%0d",
                 k, ov[2], wc, op[2], omx[2], e[k][6:4], e[k][3], e[k][2:0]);
      end
      vin[2] = 1'b0;
      tick();
      total++;
      if ({ov[2], ir[2]} !== 2'b01) begin
        bad++; $display("FAIL single_handoff k=%0d got v=%b r=%b want v=0 r=1", k, ov[2], ir[2]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 3; i++) begin
        vin[i]  = ($urandom_range(0, 3) != 0);
        din[i]  = 6'($urandom);
        ordy[i] = ($urandom_range(0, 2) != 0);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        total++;
        if ({ov[i], ir[i], op[i], omx[i], dut_w(i)} !== {mh[i], !mh[i], ep[i], em[i], ew[i]}) begin
          bad++;
          $display("FAIL random inst=%0d cyc=%0d got v=%b r=%b p=%b m=%0d w=%0d want v=%b r=%b p=%b m=%0d w=%0d",
                   i, n, ov[i], ir[i], op[i], omx[i], dut_w(i), mh[i], !mh[i], ep[i], em[i], ew[i]);
        end
      end
    end
    vin = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    test_reset_hold();
    test_default_frame();
    test_single_word();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
